// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns PC, IR and a one-word prefetch buffer, and
// turns the control unit's IRWrite/PCWrite commands into imem requests.
module fetch_unit #(
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              IRWrite,
    input  logic              PCWrite,
    input  logic              PCWriteCond,
    input  logic              Zero,
    input  logic [1:0]        PCSource,
    input  logic [DATA_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_ready,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    output logic [DATA_W-1:0] PC,
    output logic [DATA_W-1:0] IR,
    output logic [3:0]        op,
    output logic              Stall
);

    typedef enum logic {FETCH = 1'b0, VALID = 1'b1} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] buf_q;
    logic              pc_en;
    logic              ir_ld;
    logic [DATA_W-1:0] ir_word;

    // Stall gates the PC write so a combined IRWrite+PCWrite step is atomic.
    assign Stall   = ~Reset & IRWrite & (state_q == FETCH) & ~imem_ready;
    assign pc_en   = (PCWrite | (PCWriteCond & Zero)) & ~Stall & (PCSource != 2'b11);
    assign ir_ld   = IRWrite & ~Stall;
    assign ir_word = (state_q == VALID) ? buf_q : imem_rdata;

    always_comb begin
        pc_d = pc_q;
        unique case (PCSource)
            2'b00:   pc_d = pc_q + DATA_W'(PC_STEP);
            2'b01:   pc_d = ALUOut;
            2'b10:   pc_d = {pc_q[DATA_W-1:DATA_W-3], ir_q[DATA_W-5:0], 1'b0};
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            buf_q   <= '0;
        end else begin
            if (ir_ld)
                ir_q <= ir_word;
            if (pc_en)
                pc_q <= pc_d;
            unique case (state_q)
                FETCH: begin
                    // Data returning alongside a PC change belongs to the old address.
                    if (!pc_en && imem_ready) begin
                        buf_q   <= imem_rdata;
                        state_q <= VALID;
                    end
                end
                VALID: begin
                    if (pc_en)
                        state_q <= FETCH;
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    assign imem_req  = ~Reset & (state_q == FETCH);
    assign imem_addr = pc_q;
    assign PC        = pc_q;
    assign IR        = ir_q;
    assign op        = ir_q[DATA_W-1:DATA_W-4];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a behavioural model.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset, IRWrite, PCWrite, PCWriteCond, Zero, imem_ready;
    logic [1:0]  PCSource;
    logic [15:0] ALUOut, imem_rdata;
    logic        imem_req, Stall;
    logic [15:0] imem_addr, PC, IR;
    logic [3:0]  op;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: the fetch point, the IR, and whether the word at PC is already in hand.
    logic [15:0] m_pc, m_ir, m_word;
    bit          m_have;

    fetch_unit dut (
        .CLK(CLK), .Reset(Reset), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .Zero(Zero), .PCSource(PCSource),
        .ALUOut(ALUOut), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .imem_req(imem_req), .imem_addr(imem_addr), .PC(PC), .IR(IR),
        .op(op), .Stall(Stall)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem(input logic [15:0] a);
        return {a[7:0] ^ 8'h5A, ~a[15:8]} + 16'h0101;
    endfunction

    // Compare DUT against model, then advance the model by one clock.
    task automatic model_cycle();
        bit          avail, stl, en;
        logic [15:0] word, tgt;
        avail = m_have || imem_ready;
        word  = m_have ? m_word : imem_rdata;
        stl   = !Reset && IRWrite && !avail;
        chk("m_req",   {15'd0, imem_req}, {15'd0, (!Reset && !m_have)});
        chk("m_stall", {15'd0, Stall},    {15'd0, stl});
        chk("m_addr",  imem_addr, m_pc);
        chk("m_pc",    PC, m_pc);
        chk("m_ir",    IR, m_ir);
        chk("m_op",    {12'd0, op}, m_ir / 16'd4096);
        if (Reset) begin
            m_pc = 16'h0000; m_ir = 16'h0000; m_have = 0; m_word = 16'h0000;
        end else begin
            en = (PCWrite || (PCWriteCond && Zero)) && !stl && PCSource != 2'd3;
            case (PCSource)
                2'd0:    tgt = 16'((int'(m_pc) + 2) % 65536);
                2'd1:    tgt = ALUOut;
                default: tgt = (m_pc & 16'hE000) | ((m_ir % 16'd4096) * 16'd2);
            endcase
            if (IRWrite && !stl) m_ir = word;
            if (en) begin
                m_pc = tgt; m_have = 0;
            end else if (!m_have && imem_ready) begin
                m_have = 1; m_word = imem_rdata;
            end
        end
    endtask

    task automatic tick(input bit rst, input bit irw, input bit pcw, input bit pcwc,
                        input bit z, input logic [1:0] src, input logic [15:0] alu,
                        input bit rdy, input logic [15:0] rd);
        @(posedge CLK); #1;
        Reset = rst; IRWrite = irw; PCWrite = pcw; PCWriteCond = pcwc; Zero = z;
        PCSource = src; ALUOut = alu; imem_ready = rdy; imem_rdata = rd;
        @(negedge CLK);
        model_cycle();
    endtask

    initial begin
        Reset = 1; IRWrite = 0; PCWrite = 0; PCWriteCond = 0; Zero = 0;
        PCSource = 0; ALUOut = 0; imem_ready = 0; imem_rdata = 0;
        m_pc = 0; m_ir = 0; m_have = 0; m_word = 0;
        @(posedge CLK);
        @(posedge CLK);

        // Reset: request and stall held low even with IRWrite/ready present
        tick(1, 1, 0, 0, 0, 0, 0, 1, 16'h7777);
        chk("rst_req",   {15'd0, imem_req}, 16'd0);
        chk("rst_stall", {15'd0, Stall}, 16'd0);
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_pc", PC, 16'h0000);
        chk("rst_ir", IR, 16'h0000);

        // Zero-wait fetch step
        tick(0, 1, 1, 0, 0, 0, 0, 1, 16'h1234);
        chk("zw_stall", {15'd0, Stall}, 16'd0);
        chk("zw_req",   {15'd0, imem_req}, 16'd1);
        chk("zw_addr",  imem_addr, 16'h0000);
        // Three-cycle memory
        tick(0, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("zw_ir",   IR, 16'h1234);
        chk("zw_op",   {12'd0, op}, 16'h0001);
        chk("zw_pc",   PC, 16'h0002);
        chk("zw_addr2", imem_addr, 16'h0002);
        chk("w_stall1", {15'd0, Stall}, 16'd1);
        tick(0, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("w_stall2", {15'd0, Stall}, 16'd1);
        tick(0, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("w_stall3", {15'd0, Stall}, 16'd1);
        chk("w_pc_hold", PC, 16'h0002);
        tick(0, 1, 1, 0, 0, 0, 0, 1, 16'h5678);
        chk("w_stall_rdy", {15'd0, Stall}, 16'd0);
        tick(0, 0, 0, 0, 0, 0, 0, 1, 16'h2468);
        chk("w_pc", PC, 16'h0004);
        chk("w_ir", IR, 16'h5678);

        // Conditional branch, now in VALID
        tick(0, 0, 0, 1, 0, 1, 16'h0040, 0, 0);
        chk("valid_req", {15'd0, imem_req}, 16'd0);
        tick(0, 0, 0, 1, 1, 1, 16'h0040, 0, 0);
        chk("bnz_pc", PC, 16'h0004);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("bz_pc",   PC, 16'h0040);
        chk("bz_req",  {15'd0, imem_req}, 16'd1);
        chk("bz_addr", imem_addr, 16'h0040);

        // Jump target from IR
        tick(0, 1, 1, 0, 0, 1, 16'h4000, 1, 16'hA123);
        tick(0, 0, 1, 0, 0, 2, 0, 0, 0);
        chk("j_pc0", PC, 16'h4000);
        chk("j_ir",  IR, 16'hA123);
        // Stale data alongside a PC change must be discarded
        tick(0, 0, 1, 0, 0, 1, 16'h0100, 1, 16'hBEEF);
        chk("j_pc", PC, 16'h4246);
        tick(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("st_pc",    PC, 16'h0100);
        chk("st_addr",  imem_addr, 16'h0100);
        chk("st_stall", {15'd0, Stall}, 16'd1);
        tick(0, 1, 0, 0, 0, 0, 0, 1, 16'hCAFE);
        tick(0, 0, 1, 0, 0, 1, 16'hFFFE, 0, 0);
        chk("st_ir", IR, 16'hCAFE);

        // PC wrap, then reset during an outstanding request
        tick(0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("wr_pc0", PC, 16'hFFFE);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wr_pc",  PC, 16'h0000);
        chk("wr_req", {15'd0, imem_req}, 16'd1);
        tick(1, 1, 0, 0, 0, 0, 0, 1, 16'h1111);
        chk("mr_req",   {15'd0, imem_req}, 16'd0);
        chk("mr_stall", {15'd0, Stall}, 16'd0);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mr_pc", PC, 16'h0000);
        chk("mr_ir", IR, 16'h0000);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit          rdy;
            logic [15:0] rd;
            rdy = ($urandom_range(2) == 0);
            rd  = ($urandom_range(7) == 0) ? 16'($urandom) : mem(m_pc);
            tick(($urandom_range(60) == 0), $urandom_range(1), ($urandom_range(3) == 0),
                 ($urandom_range(3) == 0), $urandom_range(1), 2'($urandom_range(3)),
                 16'($urandom), rdy, rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Upstream feeder of the multicycle control unit (`state_machine`).
- Owns the program counter, the instruction memory request handshake, a one-word prefetch buffer and the instruction register.
- Exposes `op = IR[15:12]` to the control unit.
- Executes the control unit's `IRWrite`/`PCWrite`/`PCSource` commands and raises `Stall` when an instruction word is not yet available.

Parameters:
- DATA_W, 16, width of instructions, PC and ALU result
- RESET_PC, 16'h0000, PC value loaded on reset
- PC_STEP, 2, byte increment for sequential PC

Ports:
- CLK  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- IRWrite  in  1  load IR with the word at current PC
- PCWrite  in  1  unconditional PC update
- PCWriteCond  in  1  PC update only when Zero=1
- Zero  in  1  ALU zero flag
- PCSource  in  2  00 PC+PC_STEP, 01 ALUOut, 10 jump target, 11 hold
- ALUOut  in  DATA_W  ALU result (branch target)
- imem_rdata  in  DATA_W  instruction memory read data
- imem_ready  in  1  imem_rdata valid for the current request this cycle
- imem_req  out  1  instruction read request
- imem_addr  out  DATA_W  read address, always equals PC
- PC  out  DATA_W  program counter
- IR  out  DATA_W  instruction register
- op  out  4  IR[15:12], to control unit
- Stall  out  1  IRWrite could not be honoured this cycle

Behaviour:
- Reset (sync, high):
  - PC=RESET_PC, IR=0, op=0, buffer invalid, state=FETCH.
  - imem_req=0 while Reset is high. Stall=0 while Reset is high.
  - Reset mid-request abandons the request. An imem_ready in a Reset cycle is ignored.
- States:
  - FETCH: imem_req=1. Buffer empty.
  - VALID: imem_req=0. Buffer holds the word at PC.
- imem_addr = PC combinationally. A request is held until imem_ready or until PC changes.
- PC update condition: pc_en = (PCWrite | (PCWriteCond & Zero)) & ~Stall & (PCSource != 11).
- Next-PC values:
  - 00 -> PC+PC_STEP, mod 2^16 (16'hFFFE+2 wraps to 0000).
  - 01 -> ALUOut.
  - 10 -> {PC[15:13], IR[11:0], 1'b0}, built from the old IR even if IR loads the same cycle.
- FETCH transitions:
  - pc_en=1: stay FETCH with the new PC. Any same-cycle imem_ready data is discarded (stale address).
  - Else imem_ready=1: capture imem_rdata into buffer, go to VALID.
  - Else: stay FETCH.
- VALID transitions:
  - pc_en=1: go to FETCH.
  - Else: stay VALID. Repeated IRWrite reloads the same word.
- IRWrite handling:
  - In VALID: IR<=buffer, Stall=0.
  - In FETCH with imem_ready=1: bypass, IR<=imem_rdata, Stall=0.
  - In FETCH with imem_ready=0: Stall=1 (combinational), IR unchanged.
- Stall also suppresses PCWrite/PCWriteCond that cycle, so an IRWrite+PCWrite fetch step is atomic. The control unit holds its state while Stall=1.
- IRWrite with pc_en in the same cycle: IR captures the word for the old PC, then PC updates and the FETCH restarts.
- Stall=0 whenever IRWrite=0.
- Latency:
  - Zero-wait memory (ready in the first FETCH cycle): IRWrite never stalls.
  - N-cycle memory: Stall is high for N cycles of IRWrite.

Test Plan:
- Reset, then zero-wait memory returning 16'h1234 at addr 0. Pulse IRWrite+PCWrite(PCSource=00) in the first FETCH cycle -> IR=1234, op=1, PC=0002, Stall=0, imem_req re-asserts with imem_addr=0002.
- imem_ready delayed 3 cycles, IRWrite+PCWrite held -> Stall=1 for 3 cycles, PC stays 0002 throughout. On the ready cycle IR=imem_rdata, PC=0004.
- PCWriteCond=1, Zero=0, PCSource=01, ALUOut=0040 -> PC unchanged. Repeat with Zero=1 -> PC=0040, state FETCH, imem_addr=0040.
- IR=16'hA123, PC=16'h4000, PCWrite with PCSource=10 -> PC=16'h4246.
- In FETCH, PCWrite (ALUOut=0100) in the same cycle as imem_ready with data 16'hBEEF -> BEEF is not loaded on a later IRWrite. The next request goes to 0100.
- PC=16'hFFFE, sequential step -> PC=0000. Assert Reset during an outstanding request -> imem_req=0, PC=RESET_PC, IR=0 next cycle.
